// File: rtl/pea_fifo_if.sv
// pea_fifo_if: producer/consumer handshake bundle for the PEA token FIFO.
// The master modport belongs to the side driving pushes, pops and flushes.
interface pea_fifo_if #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
);
    localparam int cnt_w = $clog2(buffer_size);

    logic                 clear;
    logic                 wr_en;
    logic [word_size-1:0] data_in;
    logic                 rd_en;
    logic [word_size-1:0] data_out;
    logic [cnt_w-1:0]     population;
    logic [cnt_w-1:0]     free_space;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, population, free_space, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, population, free_space, overflow, underflow
    );
endinterface

// File: rtl/pea_fifo.sv
// pea_fifo: single-clock token FIFO with registered population/free_space counts.
// Sticky overflow/underflow flags are built only when PEA_FIFO_ERR_EN is defined.
module pea_fifo #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input logic       clk,
    input logic       rst,
    pea_fifo_if.slave bus
);
    localparam int               ptr_w   = $clog2(buffer_size);
    localparam logic [ptr_w-1:0] max_pop = ptr_w'(buffer_size - 1);

    logic [word_size-1:0] ram [buffer_size];
    logic [word_size-1:0] dout_q;
    logic [ptr_w-1:0]     wr_ptr;
    logic [ptr_w-1:0]     rd_ptr;
    logic [ptr_w-1:0]     pop_q;
    logic [ptr_w-1:0]     free_q;
    logic [ptr_w-1:0]     pop_d;
    logic [ptr_w-1:0]     free_d;
    logic                 full;
    logic                 empty;
    logic                 wr_ok;
    logic                 rd_ok;

    // full/empty come from the registered count, so they reflect pre-edge state.
    assign full  = (pop_q == max_pop);
    assign empty = (pop_q == '0);
    assign wr_ok = bus.wr_en & ~full  & ~bus.clear;
    assign rd_ok = bus.rd_en & ~empty & ~bus.clear;

    // NOTE: storage has no reset; only pointers and counts define what is valid,
    // and leaving the array unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[wr_ptr] <= bus.data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Pointer width equals log2(depth), so natural overflow is the wrap.
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A flush leaves the last popped token visible on data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= ram[rd_ptr];
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        pop_d  = pop_q;
        free_d = free_q;
        unique case ({wr_ok, rd_ok})
            2'b10: begin
                pop_d  = pop_q  + 1'b1;
                free_d = free_q - 1'b1;
            end
            2'b01: begin
                pop_d  = pop_q  - 1'b1;
                free_d = free_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_q  <= '0;
            free_q <= max_pop;
        end else if (bus.clear) begin
            pop_q  <= '0;
            free_q <= max_pop;
        end else begin
            pop_q  <= pop_d;
            free_q <= free_d;
        end
    end

`ifdef PEA_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Flags survive clear; only rst removes the record of a protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr_en & full  & ~bus.clear) ovf_q <= 1'b1;
            if (bus.rd_en & empty & ~bus.clear) unf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.data_out   = dout_q;
    assign bus.population = pop_q;
    assign bus.free_space = free_q;
endmodule

// File: tb/tb_pea_fifo.sv
// tb_pea_fifo: randomized self-checking bench for pea_fifo (depth 8, 16-bit tokens)
// against a queue-based reference model.
module tb_pea_fifo;
    localparam int WS = 16;
    localparam int BS = 8;
    localparam int CAP = BS - 1;
`ifdef PEA_FIFO_ERR_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif

    logic clk;
    logic rst;

    pea_fifo_if #(.word_size(WS), .buffer_size(BS)) bus ();

    pea_fifo #(.word_size(WS), .buffer_size(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [WS-1:0] q[$];
    logic [WS-1:0] m_dout;
    bit            m_of;
    bit            m_uf;

    function automatic void model_reset();
        q.delete();
        m_dout = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
    endfunction

    function automatic void model_step(input bit wr, input logic [WS-1:0] din,
                                       input bit rd, input bit clr);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == CAP);
        was_empty = (q.size() == 0);
        if (clr) begin
            q.delete();
        end else begin
            if (rd && !was_empty) m_dout = q.pop_front();
            if (rd && was_empty)  m_uf = 1'b1;
            if (wr && !was_full)  q.push_back(din);
            if (wr && was_full)   m_of = 1'b1;
        end
    endfunction

    function automatic int exp_pop();
        return q.size();
    endfunction

    // One clock with the given inputs; outputs are left ready to sample 1ns after the edge.
    task automatic cycle(input bit wr, input logic [WS-1:0] din, input bit rd, input bit clr);
        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        bus.clear   = clr;
        @(posedge clk);
        model_step(wr, din, rd, clr);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.population !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_population got=%0d exp=0", bus.population);
        end
        n_cmp++;
        if (bus.free_space !== 3'(CAP)) begin
            n_bad++;
            $display("FAIL reset_free_space got=%0d exp=%0d", bus.free_space, CAP);
        end
        n_cmp++;
        if (bus.data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data_out got=%h exp=0000", bus.data_out);
        end
        n_cmp++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b%b exp=00", bus.overflow, bus.underflow);
        end
        rst = 1'b1;
        cycle(0, '0, 0, 0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= CAP; i++) begin
            cycle(1, WS'(i), 0, 0);
            n_cmp++;
            if (int'(bus.population) !== exp_pop()) begin
                n_bad++;
                $display("FAIL fill_population[%0d] got=%0d exp=%0d", i, bus.population, exp_pop());
            end
        end
        cycle(1, 16'hFFFF, 0, 0);
        n_cmp++;
        if (bus.population !== 3'd7 || int'(bus.population) !== exp_pop()) begin
            n_bad++;
            $display("FAIL full_population got=%0d exp=7", bus.population);
        end
        n_cmp++;
        if (bus.free_space !== 3'd0) begin
            n_bad++;
            $display("FAIL full_free_space got=%0d exp=0", bus.free_space);
        end
        n_cmp++;
        if (bus.overflow !== (err_en & m_of)) begin
            n_bad++;
            $display("FAIL overflow got=%b exp=%b", bus.overflow, err_en & m_of);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= CAP; i++) begin
            cycle(0, '0, 1, 0);
            n_cmp++;
            if (bus.data_out !== WS'(i) || bus.data_out !== m_dout) begin
                n_bad++;
                $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus.data_out, WS'(i));
            end
        end
        cycle(0, '0, 1, 0);
        n_cmp++;
        if (bus.data_out !== 16'h0007) begin
            n_bad++;
            $display("FAIL empty_read_hold got=%h exp=0007", bus.data_out);
        end
        n_cmp++;
        if (bus.population !== 3'd0 || bus.free_space !== 3'd7) begin
            n_bad++;
            $display("FAIL empty_counts got=%0d/%0d exp=0/7", bus.population, bus.free_space);
        end
        n_cmp++;
        if (bus.underflow !== (err_en & m_uf)) begin
            n_bad++;
            $display("FAIL underflow got=%b exp=%b", bus.underflow, err_en & m_uf);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) cycle(1, WS'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, WS'($urandom), 1, 0);
            n_cmp++;
            if (bus.population !== 3'd3) begin
                n_bad++;
                $display("FAIL b2b_population[%0d] got=%0d exp=3", i, bus.population);
            end
            n_cmp++;
            if (bus.data_out !== m_dout) begin
                n_bad++;
                $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.data_out, m_dout);
            end
        end
        while (q.size() != 0) begin
            cycle(0, '0, 1, 0);
            n_cmp++;
            if (bus.data_out !== m_dout) begin
                n_bad++;
                $display("FAIL b2b_drain got=%h exp=%h", bus.data_out, m_dout);
            end
        end
        // Simultaneous access while empty: only the write lands.
        cycle(1, 16'hA5A5, 1, 0);
        n_cmp++;
        if (bus.population !== 3'd1 || bus.data_out !== m_dout) begin
            n_bad++;
            $display("FAIL empty_rw got pop=%0d data=%h exp pop=1 data=%h",
                     bus.population, bus.data_out, m_dout);
        end
        cycle(0, '0, 1, 0);
        n_cmp++;
        if (bus.data_out !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL empty_rw_read got=%h exp=a5a5", bus.data_out);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < CAP; i++) cycle(1, WS'(16'h100 + i), 0, 0);
        cycle(1, 16'hDEAD, 1, 0);
        n_cmp++;
        if (int'(bus.population) !== exp_pop() || bus.data_out !== 16'h0100) begin
            n_bad++;
            $display("FAIL full_rw got pop=%0d data=%h exp pop=%0d data=0100",
                     bus.population, bus.data_out, exp_pop());
        end
        while (q.size() != 0) begin
            cycle(0, '0, 1, 0);
            n_cmp++;
            if (bus.data_out !== m_dout) begin
                n_bad++;
                $display("FAIL full_rw_drain got=%h exp=%h", bus.data_out, m_dout);
            end
        end
    endtask

    task automatic test_clear();
        logic [WS-1:0] hold;
        logic [WS-1:0] tok;
        for (int i = 0; i < 5; i++) cycle(1, WS'($urandom), 0, 0);
        hold = m_dout;
        cycle(1, 16'h5555, 0, 1);
        n_cmp++;
        if (bus.population !== 3'd0 || bus.free_space !== 3'd7) begin
            n_bad++;
            $display("FAIL clear_counts got=%0d/%0d exp=0/7", bus.population, bus.free_space);
        end
        n_cmp++;
        if (bus.data_out !== hold) begin
            n_bad++;
            $display("FAIL clear_data_hold got=%h exp=%h", bus.data_out, hold);
        end
        tok = WS'($urandom);
        cycle(1, tok, 0, 0);
        cycle(0, '0, 1, 0);
        n_cmp++;
        if (bus.data_out !== tok || bus.population !== 3'd0) begin
            n_bad++;
            $display("FAIL clear_then_rw got=%h/%0d exp=%h/0", bus.data_out, bus.population, tok);
        end
    endtask

    task automatic test_random();
        bit wr, rd, clr;
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom_range(99) < 60);
            rd  = ($urandom_range(99) < 50);
            clr = ($urandom_range(31) == 0);
            cycle(wr, WS'($urandom), rd, clr);
            n_cmp++;
            if (bus.data_out !== m_dout || int'(bus.population) !== exp_pop() ||
                int'(bus.free_space) !== CAP - exp_pop() ||
                bus.overflow !== (err_en & m_of) || bus.underflow !== (err_en & m_uf)) begin
                n_bad++;
                $display("FAIL random[%0d] got data=%h pop=%0d free=%0d of=%b uf=%b exp data=%h pop=%0d free=%0d of=%b uf=%b",
                         i, bus.data_out, bus.population, bus.free_space, bus.overflow, bus.underflow,
                         m_dout, exp_pop(), CAP - exp_pop(), err_en & m_of, err_en & m_uf);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [WS-1:0] tok;
        for (int i = 0; i < 4; i++) cycle(1, WS'($urandom), 1, 0);
        bus.wr_en = 1'b1;
        bus.data_in = 16'hBEEF;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.population !== 3'd0 || bus.free_space !== 3'd7 || bus.data_out !== 16'h0000 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got data=%h pop=%0d free=%0d of=%b uf=%b exp 0000/0/7/0/0",
                     bus.data_out, bus.population, bus.free_space, bus.overflow, bus.underflow);
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tok = WS'($urandom);
        cycle(1, tok, 0, 0);
        cycle(1, ~tok, 1, 0);
        n_cmp++;
        if (bus.data_out !== tok || bus.population !== 3'd1) begin
            n_bad++;
            $display("FAIL post_reset got=%h/%0d exp=%h/1", bus.data_out, bus.population, tok);
        end
        cycle(0, '0, 1, 0);
        n_cmp++;
        if (bus.data_out !== ~tok) begin
            n_bad++;
            $display("FAIL post_reset_second got=%h exp=%h", bus.data_out, ~tok);
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;
        rst         = 1'b1;
        #3;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_back_to_back();
        test_full_rw();
        test_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
